// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared access-size and store-FSM state encodings
package mem_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WAIT  = 2'b10,
    WRITE = 2'b11
  } state_e;
endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - byte-lane merge of store data into a RAM word, with fault/full detection
module store_lane_merge
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]     off,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] merged,
  output logic              fault,
  output logic              full
);
  logic [3:0] nbytes;

  always_comb begin
    nbytes = 4'd1 << size;
    fault  = (size == SZ_DWORD && DATA_W == 32) || (int'(off) + int'(nbytes) > NB);
    full   = !fault && (int'(nbytes) == NB);
    merged = rdata;
    // Lanes [off, off+nbytes) take successive low bytes of the store data.
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(off) && i < int'(off) + int'(nbytes))
        merged[8*i +: 8] = wdata[8*(i - int'(off)) +: 8];
    end
  end
endmodule

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - sub-word store unit doing read-modify-write on a word-wide RAM
module store_rmw_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1,
  localparam int OW = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-OW-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              done,
  output logic              err
);
  state_e              state, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                fault_q;
  logic [1:0]          cnt;
  logic [OW-1:0]       sel_off;
  logic [1:0]          sel_size;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   merged;
  logic                fault, full, accept, sample;

  // While idle the merger classifies the incoming request; afterwards it merges the latched one.
  assign sel_off  = (state == IDLE) ? req_addr[OW-1:0] : addr_q[OW-1:0];
  assign sel_size = (state == IDLE) ? req_size : size_q;
  assign sel_data = (state == IDLE) ? req_data : data_q;
  assign accept   = req_valid && (state == IDLE);
  assign sample   = (state == WAIT) && (cnt == 2'(RAM_LAT - 1));

  store_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .off    (sel_off),
    .size   (sel_size),
    .wdata  (sel_data),
    .rdata  (ram_rdata),
    .merged (merged),
    .fault  (fault),
    .full   (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        data_q  <= req_data;
        wdata_q <= req_data;
        fault_q <= fault;
        cnt     <= '0;
      end
      if (state == WAIT) cnt <= cnt + 2'd1;
      if (sample) wdata_q <= merged;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = (fault || full) ? WRITE : READ;
      READ:    state_n = WAIT;
      WAIT:    if (sample) state_n = WRITE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes are masked during reset so an abandoned store never writes or completes.
  assign req_ready = (state == IDLE);
  assign ram_re    = (state == READ) && !rst;
  assign ram_we    = (state == WRITE) && !fault_q && !rst;
  assign done      = ram_we;
  assign err       = (state == WRITE) && fault_q && !rst;
  assign ram_addr  = addr_q[ADDR_W-1:OW];
  assign ram_wdata = wdata_q;
endmodule
